adder_display_scan: RTL
=======================

Name: adder_display_scan

Overview:
Parametrised successor to the 4-bit adder/seven-segment path. Adds two WIDTH-bit operands with carry-in and captures the result in a register. Supports sum, carry-only, accumulate and clear modes. The registered result drives a time-multiplexed, multi-digit hex seven-segment display with optional leading-zero blanking.

Parameters:
WIDTH, 8, operand width in bits.
DIGITS, 3, number of display digits; DIGITS*4 >= WIDTH+1 is required (elaboration error otherwise).
REFRESH_DIV, 50000, clock cycles each digit stays active before the scan advances; must be >= 1.
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
Cin  input  1  carry-in.
S  input  2  mode: 00 sum, 01 carry-only, 10 accumulate, 11 clear.
go  input  1  capture strobe, sampled on clk.
result  output  WIDTH+1  registered result R; bit WIDTH is the carry.
valid  output  1  one-cycle pulse after each capture.
an  output  DIGITS  digit enables, active-low, one-hot-low.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async, immediate, no clock needed):
  - R=0, valid=0, refresh counter=0, digit index=0.
  - an = all ones except bit0 low.
  - seg = pattern for '0' (1000000).
- Capture on a rising clk edge with go=1; R is unchanged when go=0. Mode actions:
  - 00: R <= A+B+Cin, full WIDTH+1-bit result.
  - 01: R <= {WIDTH zeros, carry-out of A+B+Cin}.
  - 10: R <= R[WIDTH-1:0] + A + Cin. The old R[WIDTH] is discarded; the new carry goes to bit WIDTH.
  - 11: R <= 0.
- valid is registered: it is 1 in the cycle after any capture edge, otherwise 0. Back-to-back go gives continuous valid.
- Latency: result, seg and an reflect the new R from the capture edge; no extra pipeline stage.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge, digit index advances idx -> idx+1, and DIGITS-1 -> 0.
  - an[idx] = 0, all other bits = 1.
  - Captures do not reset the counter or index.
- Digit value: nibble idx of R zero-extended to DIGITS*4 bits, decoded combinationally from the registered R and idx.
- Hex patterns, active-low gfedcba:
  - 0=1000000 1=1111001 2=0100100 3=0110000
  - 4=0011001 5=0010010 6=0000010 7=1111000
  - 8=0000000 9=0010000 A=0001000 b=0000011
  - C=1000110 d=0100001 E=0000110 F=0001110
  - blank=1111111
- Blanking (BLANK_LZ=1): digit k>0 is blank when nibbles k..DIGITS-1 of R are all zero. The an enable still cycles normally.
- Boundaries:
  - REFRESH_DIV=1: the index advances every cycle.
  - A=B=all-ones with Cin=1: R = 2^(WIDTH+1)-1, no truncation.
  - Accumulate wrap: bit WIDTH reflects only the latest add and is not sticky.
  - rst asserted with go in the same cycle: reset wins.
  - rst deasserts mid-scan: scanning restarts from digit 0 with counter 0.

Test Plan:
(WIDTH=8, DIGITS=3, REFRESH_DIV=4, BLANK_LZ=1)
- Assert rst with no clock -> result=0, valid=0, an=110, seg=1000000. Release rst and run 12 cycles -> an sequence 110,101,011 with each value held 4 cycles, seg digits 0/blank/blank.
- A=FF, B=01, Cin=0, S=00, go for 1 cycle -> next cycle result=9'h100, valid=1 for exactly 1 cycle; seg shows digit0=1000000, digit1=1000000, digit2=1111001.
- Same operands with S=01 -> result=9'h001. Digits 1 and 2 blank (1111111), digit0=1111001. Repeat with BLANK_LZ=0 -> digits 1 and 2 show 1000000.
- Clear with S=11, then S=10, A=80, Cin=0, go for 3 consecutive cycles -> result 080, 100, 080; valid high for 3 cycles.
- A=FF, B=FF, Cin=1, S=00 -> result=9'h1FF; digits 1, F, F = 1111001, 0001110, 0001110.
- Mid-scan (an=101) assert rst together with go -> asynchronously result=0, an=110, valid=0; the capture is lost. After release the scan resumes from digit 0 with a 4-cycle dwell.

Source files
------------

// File: rtl/adder_display_scan.sv
// adder_display_scan: WIDTH-bit adder with carry-in and a registered result.
// The result is shown on a time-multiplexed, multi-digit hex seven-segment
// display. Leading-zero blanking is optional.
//
// Capture modes on go (S):
//   00 sum         R <= A + B + Cin, full WIDTH+1-bit result
//   01 carry-only  R <= carry-out of A + B + Cin
//   10 accumulate  R <= R[WIDTH-1:0] + A + Cin; the new carry lands in R[WIDTH]
//   11 clear       R <= 0
module adder_display_scan #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Cin,
  input  logic [1:0]        S,
  input  logic              go,
  output logic [WIDTH:0]    result,
  output logic              valid,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int RW = WIDTH + 1;
  localparam int DW = DIGITS * 4;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Reject parameter sets that cannot display the full result or cannot scan.
  generate
    if (DW < RW) begin : g_bad_digits
      $error("adder_display_scan: DIGITS*4 must be >= WIDTH+1");
    end
    if (REFRESH_DIV < 1) begin : g_bad_refresh
      $error("adder_display_scan: REFRESH_DIV must be >= 1");
    end
  endgenerate

  logic [RW-1:0] r_q, r_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [RW-1:0] sum_full;
  logic [RW-1:0] acc_full;

  // Compute the next result from the mode. Accumulate drops the old carry bit.
  always_comb begin
    sum_full = RW'(A) + RW'(B) + RW'(Cin);
    acc_full = RW'(r_q[WIDTH-1:0]) + RW'(A) + RW'(Cin);
    r_d      = r_q;
    valid_d  = go;
    if (go) begin
      case (S)
        2'b00:   r_d = sum_full;
        2'b01:   r_d = RW'(sum_full[WIDTH]);
        2'b10:   r_d = acc_full;
        default: r_d = '0;
      endcase
    end
  end

  // Advance the refresh counter. On its wrap, step the digit index, which
  // wraps from DIGITS-1 back to 0.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Hold the result, the valid strobe and the scan position. Async reset wins over go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      r_q     <= r_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  logic [DW-1:0]     r_ext;
  logic [DIGITS-1:0] zero_from;
  logic              above_nz;
  logic [3:0]        nib;
  logic              blank;
  logic [DIGITS-1:0] an_c;
  logic [6:0]        seg_hex;

  // Select the active nibble and its anode. A digit above 0 blanks when it and
  // every higher nibble are zero.
  always_comb begin
    r_ext     = DW'(r_q);
    above_nz  = 1'b0;
    zero_from = '0;
    nib       = 4'h0;
    blank     = 1'b0;
    an_c      = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      above_nz     = above_nz | (r_ext[k*4 +: 4] != 4'h0);
      zero_from[k] = ~above_nz;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib     = r_ext[k*4 +: 4];
        blank   = (BLANK_LZ != 0) && (k != 0) && zero_from[k];
        an_c[k] = 1'b0;
      end
    end
  end

  // Decode the hex nibble to active-low segments {g,f,e,d,c,b,a}.
  always_comb begin
    case (nib)
      4'h0:    seg_hex = 7'b1000000;
      4'h1:    seg_hex = 7'b1111001;
      4'h2:    seg_hex = 7'b0100100;
      4'h3:    seg_hex = 7'b0110000;
      4'h4:    seg_hex = 7'b0011001;
      4'h5:    seg_hex = 7'b0010010;
      4'h6:    seg_hex = 7'b0000010;
      4'h7:    seg_hex = 7'b1111000;
      4'h8:    seg_hex = 7'b0000000;
      4'h9:    seg_hex = 7'b0010000;
      4'hA:    seg_hex = 7'b0001000;
      4'hB:    seg_hex = 7'b0000011;
      4'hC:    seg_hex = 7'b1000110;
      4'hD:    seg_hex = 7'b0100001;
      4'hE:    seg_hex = 7'b0000110;
      default: seg_hex = 7'b0001110;
    endcase
  end

  assign result = r_q;
  assign valid  = valid_q;
  assign an     = an_c;
  assign seg    = blank ? 7'b1111111 : seg_hex;

endmodule
